// File: rtl/jt51_pg_ctrl_pkg.sv
// Shared definitions for the phase-generator control block: write-select
// field encodings, table depths, field widths and pipeline delays.
package jt51_pg_ctrl_pkg;

    typedef enum logic [2:0] {
        SEL_KC    = 3'd0,
        SEL_KF    = 3'd1,
        SEL_PMS   = 3'd2,
        SEL_MUL   = 3'd3,
        SEL_DT1   = 3'd4,
        SEL_DT2   = 3'd5,
        SEL_KEYON = 3'd6,
        SEL_RSVD  = 3'd7
    } wr_sel_e;

    localparam int CH_DEPTH = 8;
    localparam int OP_DEPTH = 32;

    localparam int KC_W  = 7;
    localparam int KF_W  = 6;
    localparam int PMS_W = 3;
    localparam int MUL_W = 4;
    localparam int DT1_W = 3;
    localparam int DT2_W = 2;

    // Register stages after stage I for each late output.
    localparam int DLY_DT1    = 1;
    localparam int DLY_PG_RST = 2;
    localparam int DLY_MUL    = 5;

    typedef struct packed {
        logic [KC_W-1:0]  kc;
        logic [KF_W-1:0]  kf;
        logic [PMS_W-1:0] pms;
    } ch_entry_t;

    typedef struct packed {
        logic [MUL_W-1:0] mul;
        logic [DT1_W-1:0] dt1;
        logic [DT2_W-1:0] dt2;
    } op_entry_t;

endpackage

// File: rtl/jt51_pg_ctrl_dly.sv
// Fixed-length delay line with synchronous clear.
module jt51_pg_ctrl_dly #(
    parameter int width  = 1,
    parameter int stages = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    logic [width-1:0] pipe_q [stages];
    logic [width-1:0] pipe_d [stages];

    // Shift one position per cycle.
    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < stages; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline registers; reset flushes in-flight values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < stages; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[stages-1];

endmodule

// File: rtl/jt51_pg_ctrl.sv
// Phase-generator control: slot sequencer, channel/operator parameter
// tables, key-on pending bits and the stage-aligned output pipeline.
// Optional readback port enabled by defining JT51_PG_RDBACK_EN.
module jt51_pg_ctrl
    import jt51_pg_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    output logic             wr_ack,
    input  logic [2:0]       wr_sel,
    input  logic [4:0]       wr_addr,
    input  logic [7:0]       wr_din,
    output logic             zero,
    output logic [KC_W-1:0]  kc_I,
    output logic [KF_W-1:0]  kf_I,
    output logic [PMS_W-1:0] pms_I,
    output logic [DT2_W-1:0] dt2_I,
    output logic [DT1_W-1:0] dt1_II,
    output logic             pg_rst_III,
    output logic [MUL_W-1:0] mul_VI
`ifdef JT51_PG_RDBACK_EN
    ,
    input  logic [2:0]       rd_sel,
    input  logic [4:0]       rd_addr,
    output logic [7:0]       rd_dout
`endif
);

    logic [4:0]       slot_q, slot_d;
    ch_entry_t        ch_q [CH_DEPTH];
    ch_entry_t        ch_d [CH_DEPTH];
    op_entry_t        op_q [OP_DEPTH];
    op_entry_t        op_d [OP_DEPTH];
    logic [31:0]      pend_q, pend_d;

    logic             zero_q, zero_d;
    logic [KC_W-1:0]  kc_q, kc_d;
    logic [KF_W-1:0]  kf_q, kf_d;
    logic [PMS_W-1:0] pms_q, pms_d;
    logic [DT2_W-1:0] dt2_q, dt2_d;
    logic [DT1_W-1:0] dt1_i_q, dt1_i_d;
    logic             pg_rst_i_q, pg_rst_i_d;
    logic [MUL_W-1:0] mul_i_q, mul_i_d;

    wr_sel_e          sel;
    logic             wr_hit;
    logic             unused_din;

    assign sel        = wr_sel_e'(wr_sel);
    assign unused_din = wr_din[7];

    // A write collides when it targets the entry the sequencer reads now.
    always_comb begin
        wr_hit = 1'b0;
        case (sel)
            SEL_KC, SEL_KF, SEL_PMS:           wr_hit = (wr_addr[2:0] == slot_q[2:0]);
            SEL_MUL, SEL_DT1, SEL_DT2, SEL_KEYON: wr_hit = (wr_addr == slot_q);
            default:                           wr_hit = 1'b0;
        endcase
    end

    assign wr_ack = wr_req & ~rst & ~wr_hit;

    // Slot read, key-on service and table update.
    always_comb begin
        slot_d     = slot_q + 5'd1;
        ch_d       = ch_q;
        op_d       = op_q;
        pend_d     = pend_q;

        zero_d     = (slot_q == 5'd0);
        kc_d       = ch_q[slot_q[2:0]].kc;
        kf_d       = ch_q[slot_q[2:0]].kf;
        pms_d      = ch_q[slot_q[2:0]].pms;
        dt2_d      = op_q[slot_q].dt2;
        dt1_i_d    = op_q[slot_q].dt1;
        mul_i_d    = op_q[slot_q].mul;
        pg_rst_i_d = pend_q[slot_q];
        pend_d[slot_q] = 1'b0;

        // Collision-free by construction, so no ordering against the clear.
        if (wr_ack) begin
            case (sel)
                SEL_KC:    ch_d[wr_addr[2:0]].kc  = wr_din[KC_W-1:0];
                SEL_KF:    ch_d[wr_addr[2:0]].kf  = wr_din[KF_W-1:0];
                SEL_PMS:   ch_d[wr_addr[2:0]].pms = wr_din[PMS_W-1:0];
                SEL_MUL:   op_d[wr_addr].mul      = wr_din[MUL_W-1:0];
                SEL_DT1:   op_d[wr_addr].dt1      = wr_din[DT1_W-1:0];
                SEL_DT2:   op_d[wr_addr].dt2      = wr_din[DT2_W-1:0];
                SEL_KEYON: if (wr_din[0]) pend_d[wr_addr] = 1'b1;
                default:   ;
            endcase
        end
    end

    // State and stage-I registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            for (int i = 0; i < CH_DEPTH; i++) ch_q[i] <= '0;
            for (int i = 0; i < OP_DEPTH; i++) op_q[i] <= '0;
            pend_q     <= '0;
            zero_q     <= 1'b0;
            kc_q       <= '0;
            kf_q       <= '0;
            pms_q      <= '0;
            dt2_q      <= '0;
            dt1_i_q    <= '0;
            pg_rst_i_q <= 1'b0;
            mul_i_q    <= '0;
        end else begin
            slot_q     <= slot_d;
            ch_q       <= ch_d;
            op_q       <= op_d;
            pend_q     <= pend_d;
            zero_q     <= zero_d;
            kc_q       <= kc_d;
            kf_q       <= kf_d;
            pms_q      <= pms_d;
            dt2_q      <= dt2_d;
            dt1_i_q    <= dt1_i_d;
            pg_rst_i_q <= pg_rst_i_d;
            mul_i_q    <= mul_i_d;
        end
    end

    assign zero  = zero_q;
    assign kc_I  = kc_q;
    assign kf_I  = kf_q;
    assign pms_I = pms_q;
    assign dt2_I = dt2_q;

    jt51_pg_ctrl_dly #(.width(DT1_W), .stages(DLY_DT1)) u_dly_dt1 (
        .clk (clk), .rst (rst), .din (dt1_i_q), .dout (dt1_II)
    );

    jt51_pg_ctrl_dly #(.width(1), .stages(DLY_PG_RST)) u_dly_pg_rst (
        .clk (clk), .rst (rst), .din (pg_rst_i_q), .dout (pg_rst_III)
    );

    jt51_pg_ctrl_dly #(.width(MUL_W), .stages(DLY_MUL)) u_dly_mul (
        .clk (clk), .rst (rst), .din (mul_i_q), .dout (mul_VI)
    );

`ifdef JT51_PG_RDBACK_EN
    logic [7:0] rd_dout_q, rd_dout_d;

    // Field lookup for the readback port, zero-extended.
    always_comb begin
        rd_dout_d = '0;
        case (wr_sel_e'(rd_sel))
            SEL_KC:    rd_dout_d = 8'(ch_q[rd_addr[2:0]].kc);
            SEL_KF:    rd_dout_d = 8'(ch_q[rd_addr[2:0]].kf);
            SEL_PMS:   rd_dout_d = 8'(ch_q[rd_addr[2:0]].pms);
            SEL_MUL:   rd_dout_d = 8'(op_q[rd_addr].mul);
            SEL_DT1:   rd_dout_d = 8'(op_q[rd_addr].dt1);
            SEL_DT2:   rd_dout_d = 8'(op_q[rd_addr].dt2);
            SEL_KEYON: rd_dout_d = 8'(pend_q[rd_addr]);
            default:   rd_dout_d = '0;
        endcase
    end

    // Registered readback data.
    always_ff @(posedge clk) begin
        if (rst) rd_dout_q <= '0;
        else     rd_dout_q <= rd_dout_d;
    end

    assign rd_dout = rd_dout_q;
`endif

endmodule

// File: tb/tb_jt51_pg_ctrl.sv
// Testbench for jt51_pg_ctrl: reference model plus directed, table and
// random stimulus. Readback checks active when JT51_PG_RDBACK_EN is defined.
module tb_jt51_pg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_req = 1'b0;
    logic [2:0] wr_sel = '0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_din = '0;
    logic       wr_ack;
    logic       zero;
    logic [6:0] kc_I;
    logic [5:0] kf_I;
    logic [2:0] pms_I;
    logic [1:0] dt2_I;
    logic [2:0] dt1_II;
    logic       pg_rst_III;
    logic [3:0] mul_VI;
`ifdef JT51_PG_RDBACK_EN
    logic [2:0] rd_sel = '0;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_dout;
`endif

    always #5 clk = ~clk;

    jt51_pg_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_ack     (wr_ack),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_din     (wr_din),
        .zero       (zero),
        .kc_I       (kc_I),
        .kf_I       (kf_I),
        .pms_I      (pms_I),
        .dt2_I      (dt2_I),
        .dt1_II     (dt1_II),
        .pg_rst_III (pg_rst_III),
        .mul_VI     (mul_VI)
`ifdef JT51_PG_RDBACK_EN
        ,
        .rd_sel     (rd_sel),
        .rd_addr    (rd_addr),
        .rd_dout    (rd_dout)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, want, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int z, kc, kf, pms, dt2, dt1, pg, mul;
    } rec_t;

    int   m_slot;
    int   m_kc[8], m_kf[8], m_pms[8];
    int   m_mul[32], m_dt1[32], m_dt2[32];
    int   m_pend[32];
    int   m_rd;
    rec_t hist[$];   // hist[k] = what stage I showed k cycles ago

    function automatic void model_reset();
        rec_t r;
        r = '{default: 0};
        m_slot = 0;
        m_rd   = 0;
        for (int i = 0; i < 8; i++) begin m_kc[i] = 0; m_kf[i] = 0; m_pms[i] = 0; end
        for (int i = 0; i < 32; i++) begin
            m_mul[i] = 0; m_dt1[i] = 0; m_dt2[i] = 0; m_pend[i] = 0;
        end
        hist.delete();
        for (int i = 0; i < 6; i++) hist.push_back(r);
    endfunction

    function automatic bit model_busy(input int sel, input int addr);
        if (sel <= 2) return (addr % 8) == (m_slot % 8);
        if (sel <= 6) return addr == m_slot;
        return 1'b0;
    endfunction

    function automatic int model_field(input int sel, input int addr);
        case (sel)
            0: return m_kc[addr % 8];
            1: return m_kf[addr % 8];
            2: return m_pms[addr % 8];
            3: return m_mul[addr];
            4: return m_dt1[addr];
            5: return m_dt2[addr];
            6: return m_pend[addr];
            default: return 0;
        endcase
    endfunction

    function automatic void model_write(input int sel, input int addr, input int din);
        case (sel)
            0: m_kc[addr % 8]  = din % 128;
            1: m_kf[addr % 8]  = din % 64;
            2: m_pms[addr % 8] = din % 8;
            3: m_mul[addr]     = din % 16;
            4: m_dt1[addr]     = din % 8;
            5: m_dt2[addr]     = din % 4;
            6: if (din % 2 == 1) m_pend[addr] = 1;
            default: ;
        endcase
    endfunction

    // One clock: check ack before the edge, advance model, check outputs after.
    task automatic step(output bit ack_dut);
        bit   exp_ack;
        rec_t r;
        @(negedge clk);
        ack_dut = wr_ack;
        exp_ack = wr_req && !rst && !model_busy(int'(wr_sel), int'(wr_addr));
        check("wr_ack", int'(wr_ack), int'(exp_ack));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            r.z   = (m_slot == 0) ? 1 : 0;
            r.kc  = m_kc[m_slot % 8];
            r.kf  = m_kf[m_slot % 8];
            r.pms = m_pms[m_slot % 8];
            r.dt2 = m_dt2[m_slot];
            r.dt1 = m_dt1[m_slot];
            r.mul = m_mul[m_slot];
            r.pg  = m_pend[m_slot];
`ifdef JT51_PG_RDBACK_EN
            m_rd = model_field(int'(rd_sel), int'(rd_addr));
`endif
            m_pend[m_slot] = 0;
            if (exp_ack) model_write(int'(wr_sel), int'(wr_addr), int'(wr_din));
            hist.push_front(r);
            void'(hist.pop_back());
            m_slot = (m_slot + 1) % 32;
        end
        #1;
        check("zero",       int'(zero),       hist[0].z);
        check("kc_I",       int'(kc_I),       hist[0].kc);
        check("kf_I",       int'(kf_I),       hist[0].kf);
        check("pms_I",      int'(pms_I),      hist[0].pms);
        check("dt2_I",      int'(dt2_I),      hist[0].dt2);
        check("dt1_II",     int'(dt1_II),     hist[1].dt1);
        check("pg_rst_III", int'(pg_rst_III), hist[2].pg);
        check("mul_VI",     int'(mul_VI),     hist[5].mul);
`ifdef JT51_PG_RDBACK_EN
        check("rd_dout",    int'(rd_dout),    m_rd);
`endif
    endtask

    task automatic do_reset();
        bit a;
        rst = 1'b1;
        wr_req = 1'b0;
        step(a);
        step(a);
        rst = 1'b0;
    endtask

    task automatic wait_slot(input int s);
        bit a;
        for (int i = 0; i < 40 && m_slot != s; i++) step(a);
    endtask

    task automatic wr(input int sel, input int addr, input int din, output int nacks);
        bit a;
        a = 1'b0;
        nacks = 0;
        wr_sel = 3'(sel); wr_addr = 5'(addr); wr_din = 8'(din); wr_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(a);
            if (a) break;
            nacks++;
        end
        wr_req = 1'b0;
        if (!a) check("wr_ack_timeout", 0, 1);
    endtask

    typedef struct {
        int sel, addr, din, ack;
    } vec_t;

    vec_t vecs[14];

    initial begin
        bit       a;
        int       n, pulses, at, first, second, any_nz;
        bit [31:0] mask;

        // vector i is presented while the counter sits on slot i
        vecs[0]  = '{0,  2, 8'h7F, 1};
        vecs[1]  = '{1,  2, 8'h15, 1};
        vecs[2]  = '{2,  2, 8'h05, 0};
        vecs[3]  = '{2,  2, 8'h05, 1};
        vecs[4]  = '{3,  4, 8'h09, 0};
        vecs[5]  = '{3,  4, 8'h09, 1};
        vecs[6]  = '{5, 14, 8'h03, 1};
        vecs[7]  = '{6,  7, 8'h01, 0};
        vecs[8]  = '{6,  7, 8'h01, 1};
        vecs[9]  = '{7,  9, 8'hFF, 1};
        vecs[10] = '{0, 18, 8'h11, 0};
        vecs[11] = '{6, 20, 8'h00, 1};
        vecs[12] = '{4, 12, 8'h05, 0};
        vecs[13] = '{4, 12, 8'h05, 1};

        model_reset();

        // Reset: outputs zero, requests during reset not acknowledged.
        rst = 1'b1;
        wr_req = 1'b1; wr_sel = 3'd0; wr_addr = 5'd5; wr_din = 8'h33;
        for (int i = 0; i < 3; i++) begin
            step(a);
            check("ack_in_reset", int'(a), 0);
        end
        wr_req = 1'b0;
        rst = 1'b0;

        // Idle: zero pulses at cycles 1 and 33, parameters all zero.
        first = -1; second = -1; pulses = 0; any_nz = 0;
        for (int k = 1; k <= 64; k++) begin
            step(a);
            if (zero) begin
                pulses++;
                if (first < 0) first = k; else if (second < 0) second = k;
            end
            if (kc_I != 0 || kf_I != 0 || pms_I != 0 || dt2_I != 0 ||
                dt1_II != 0 || pg_rst_III != 0 || mul_VI != 0) any_nz = 1;
        end
        check("zero_first", first, 1);
        check("zero_second", second, 33);
        check("zero_count", pulses, 2);
        check("idle_params", any_nz, 0);

        // Table: one write per cycle starting at slot 0.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            wr_sel = 3'(vecs[i].sel); wr_addr = 5'(vecs[i].addr);
            wr_din = 8'(vecs[i].din); wr_req = 1'b1;
            step(a);
            check($sformatf("vec%0d_ack", i), int'(a), vecs[i].ack);
        end
        wr_req = 1'b0;
        for (int i = 0; i < 40; i++) step(a);

        // kc=0x4A to channel 3 at slot 0.
        do_reset();
        wr(0, 3, 8'h4A, n);
        check("kc_nacks", n, 0);
        mask = '0;
        for (int i = 0; i < 32; i++) begin
            step(a);
            if (kc_I == 7'h4A) mask |= 32'd1 << ((m_slot + 31) % 32);
        end
        check("kc_slot_mask", int'(mask), 32'h0808_0808);

        // mul=5 to slot 9 while slot 9 is read: deferred one cycle.
        do_reset();
        wait_slot(9);
        wr(3, 9, 5, n);
        check("mul_nacks", n, 1);
        wait_slot(10);
        for (int i = 0; i < 4; i++) step(a);
        check("mul_VI_before", int'(mul_VI), 0);
        step(a);
        check("mul_VI_slot9", int'(mul_VI), 5);

        // Two key-ons to slot 20 before service: single pulse.
        do_reset();
        wait_slot(2);
        wr(6, 20, 1, n);
        check("keyon1_nacks", n, 0);
        wait_slot(4);
        wr(6, 20, 1, n);
        check("keyon2_nacks", n, 0);
        pulses = 0; at = -1;
        for (int i = 0; i < 70; i++) begin
            step(a);
            if (pg_rst_III) begin pulses++; at = m_slot; end
        end
        check("keyon_pulses", pulses, 1);
        check("keyon_pulse_time", at, 23);

        // Key-on slot 7, reset at slot 5: nothing fires afterwards.
        do_reset();
        wait_slot(1);
        wr(6, 7, 1, n);
        wait_slot(5);
`ifdef JT51_PG_RDBACK_EN
        rd_sel = 3'd6; rd_addr = 5'd7;
        step(a);
        check("pend7_before_rst", int'(rd_dout), 1);
`endif
        rst = 1'b1;
        step(a);
        step(a);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step(a);
            if (pg_rst_III) pulses++;
        end
        check("pulses_after_rst", pulses, 0);
`ifdef JT51_PG_RDBACK_EN
        step(a);
        check("pend7_after_rst", int'(rd_dout), 0);

        // dt1=6 to slot 30, read back.
        do_reset();
        wr(4, 30, 6, n);
        rd_sel = 3'd4; rd_addr = 5'd30;
        step(a);
        check("rd_dt1_30", int'(rd_dout), 6);
`endif

        // Random traffic against the model, requests held until acked.
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            if (!wr_req && ($urandom_range(0, 1) == 1)) begin
                wr_sel  = 3'($urandom_range(0, 7));
                wr_addr = ($urandom_range(0, 3) == 0) ? 5'(m_slot) : 5'($urandom_range(0, 31));
                wr_din  = 8'($urandom_range(0, 255));
                wr_req  = 1'b1;
            end
`ifdef JT51_PG_RDBACK_EN
            rd_sel  = 3'($urandom_range(0, 7));
            rd_addr = 5'($urandom_range(0, 31));
`endif
            rst = ($urandom_range(0, 299) == 0);
            step(a);
            if (a) wr_req = 1'b0;
        end
        rst = 1'b0;
        wr_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jt51_pg_ctrl.md
JT51_PG_CTRL -- requirements
Module: jt51_pg_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 wr_req  in  1  CPU write request, held until acknowledged.
REQ-004 wr_ack  out  1  write accepted this cycle.
REQ-005 wr_sel  in  3  target field: 0=kc, 1=kf, 2=pms, 3=mul, 4=dt1, 5=dt2, 6=key-on, 7=reserved.
REQ-006 wr_addr  in  5  slot (operator fields), channel in [2:0] (kc/kf/pms), slot (key-on).
REQ-007 wr_din  in  8  write data; the field's LSBs are used.
REQ-008 zero  out  1  high during slot 0 at stage I.
REQ-009 kc_I / kf_I / pms_I / dt2_I  out  7/6/3/2  channel/op parameters for the current slot.
REQ-010 dt1_II  out  3  dt1, one cycle after stage I.
REQ-011 pg_rst_III  out  1  phase reset, two cycles after stage I.
REQ-012 mul_VI  out  4  mul, five cycles after stage I.

Function
REQ-013 A 5-bit slot counter shall increment every cycle, wrapping 31 to 0; channel = slot[2:0], operator = slot[4:3].
REQ-014 Storage: 8-entry channel table {kc[6:0], kf[5:0], pms[2:0]} and 32-entry operator table {mul[3:0], dt1[2:0], dt2[1:0]}.
REQ-015 Stage-I outputs shall be registered reads of the entries addressed by the current slot; zero shall be asserted with the slot-0 values.
REQ-016 dt1_II, pg_rst_III and mul_VI shall be delayed copies of the same slot's values by 1, 2 and 5 registers respectively.
REQ-017 A write whose addressed entry is being read this cycle shall be deferred: wr_ack low, write retried next cycle; otherwise wr_ack shall be high in the same cycle as wr_req and the entry updated at that edge.
REQ-018 wr_sel=7 shall be acknowledged with no state change.
REQ-019 Key-on write (wr_sel=6, wr_din[0]=1) shall set pending[wr_addr]; wr_din[0]=0 shall be acknowledged and ignored.
REQ-020 When the counter reaches slot s with pending[s]=1, pending[s] shall clear and pg_rst shall assert for that slot, reaching pg_rst_III two cycles later.
REQ-021 Key-on to the slot being served: the key-on write shall be deferred per REQ-017, so pending is set after service and the reset fires on the next pass (32 cycles later).
REQ-022 Back-to-back key-ons to one slot before service shall produce a single pg_rst pulse.

Reset
REQ-023 While rst is high: slot counter = 0, all table entries = 0, pending = 0, all pipeline registers and outputs = 0, wr_ack = 0.
REQ-024 In the first cycle after rst deasserts, zero=1 with slot-0 values; writes requested during reset shall not be acknowledged.
REQ-025 Reset mid-operation shall discard pending key-ons and in-flight pipeline values.

Configuration
REQ-026 JT51_PG_RDBACK_EN defined: add ports rd_sel[2:0] in, rd_addr[4:0] in, rd_dout[7:0] out; rd_dout shall be registered, one-cycle latency, zero-extended field value, pending bit for rd_sel=6, 0 for rd_sel=7, and reset to 0.
REQ-027 JT51_PG_RDBACK_EN undefined: those ports and the readback logic shall be absent; all other behaviour shall be identical.

Structure
REQ-028 A shared package shall hold the wr_sel field encodings, table depths (8, 32), field widths, and pipeline delay constants (1, 2, 5).
REQ-029 The delay lines shall be built from one sub-module, jt51_pg_ctrl_dly (parameters width, stages).
REQ-030 Tables shall use inferable register arrays; no vendor primitives.

Verification
REQ-031 After reset, with no writes: zero pulses every 32 cycles, the first pulse in cycle 1 after reset, and all parameter outputs are 0.
REQ-032 Write kc=0x4A to channel 3 while the counter is on slot 0 -> wr_ack in the same cycle; kc_I=0x4A at slots 3, 11, 19 and 27.
REQ-033 Write mul=5 to slot 9 while slot 9 is being read -> wr_ack low one cycle, then high; mul_VI=5 five cycles after slot 9's stage I on the next pass.
REQ-034 Key-on slot 20 issued twice at slot 2 and slot 4 -> exactly one pg_rst_III pulse, 2 cycles after slot 20's stage I, then none on the following pass.
REQ-035 Key-on slot 7 set, then rst asserted at slot 5 -> no pg_rst_III pulse after reset, and pending reads back 0 with JT51_PG_RDBACK_EN defined.
REQ-036 With JT51_PG_RDBACK_EN defined, write dt1=6 to slot 30, then read rd_sel=4, rd_addr=30 -> rd_dout=0x06 one cycle later.
